// File: rtl/sd_dnsizer_pkg.sv
// ============================================================================
// Module : sd_dnsizer_pkg
// Brief  : Shared types for the sd_dnsizer width down-converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_dnsizer_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } dn_state_t;

endpackage : sd_dnsizer_pkg

`default_nettype wire

// File: rtl/sd_dnsizer.sv
// ============================================================================
// Module : sd_dnsizer
// Brief  : Srdy/drdy width down-converter. It takes one wide word of up to
//          RATIO beats and emits the beats one per cycle, LSB beat first,
//          and marks the final beat with p_last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_dnsizer
    import sd_dnsizer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    localparam int CNTW = $clog2(RATIO)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     c_srdy,
    output logic                     c_drdy,
    input  logic [WIDTH*RATIO-1:0]   c_data,
    input  logic [CNTW-1:0]          c_beats,
    output logic                     p_srdy,
    input  logic                     p_drdy,
    output logic [WIDTH-1:0]         p_data,
    output logic                     p_last
);

    localparam logic [CNTW-1:0] C_MAX_IDX = CNTW'(RATIO - 1);

    dn_state_t                    state_q, state_d;
    logic [RATIO-1:0][WIDTH-1:0]  data_q,  data_d;
    logic [CNTW-1:0]              last_q,  last_d;
    logic [CNTW-1:0]              idx_q,   idx_d;

    logic                         at_last;
    logic                         drain_last;
    logic                         load;
    logic [CNTW-1:0]              beats_clamped;

    assign at_last    = (idx_q == last_q);
    assign drain_last = (state_q == ST_SEND) && p_drdy && at_last;
    assign c_drdy     = (state_q == ST_EMPTY) || drain_last;
    assign load       = c_srdy && c_drdy;

    // A non-power-of-two RATIO leaves beat counts that name nonexistent beats.
    assign beats_clamped = (c_beats > C_MAX_IDX) ? C_MAX_IDX : c_beats;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_SEND;
                    data_d  = c_data;
                    last_d  = beats_clamped;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (p_drdy) begin
                    if (!at_last) begin
                        idx_d = idx_q + CNTW'(1);
                    end else if (load) begin
                        // Refill on the draining beat so the output never bubbles.
                        data_d = c_data;
                        last_d = beats_clamped;
                        idx_d  = '0;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            last_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    // Payload is only ever read while SEND, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign p_srdy = (state_q == ST_SEND);
    assign p_data = data_q[idx_q];
    assign p_last = at_last && p_srdy;

endmodule : sd_dnsizer

`default_nettype wire

// File: tb/tb_sd_dnsizer.sv
// ============================================================================
// Module : tb_sd_dnsizer
// Brief  : Self-checking bench for sd_dnsizer (RATIO=4 and a clamping RATIO=3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_dnsizer;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        c_srdy4, c_drdy4, p_srdy4, p_drdy4, p_last4;
    logic [31:0] c_data4;
    logic [1:0]  c_beats4;
    logic [7:0]  p_data4;

    logic        c_srdy3, c_drdy3, p_srdy3, p_drdy3, p_last3;
    logic [23:0] c_data3;
    logic [1:0]  c_beats3;
    logic [7:0]  p_data3;

    beat_t q4[$];
    beat_t q3[$];

    int n_cmp = 0;
    int n_bad = 0;
    int words4 = 0, lasts4 = 0, words3 = 0, lasts3 = 0;

    logic       stall4 = 1'b0, stall3 = 1'b0;
    logic [7:0] hd4, hd3;
    logic       hl4, hl3;

    always #5 clk = ~clk;

    sd_dnsizer #(.WIDTH(8), .RATIO(4)) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy4),
        .c_drdy  (c_drdy4),
        .c_data  (c_data4),
        .c_beats (c_beats4),
        .p_srdy  (p_srdy4),
        .p_drdy  (p_drdy4),
        .p_data  (p_data4),
        .p_last  (p_last4)
    );

    sd_dnsizer #(.WIDTH(8), .RATIO(3)) u_dut3 (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy3),
        .c_drdy  (c_drdy3),
        .c_data  (c_data3),
        .c_beats (c_beats3),
        .p_srdy  (p_srdy3),
        .p_drdy  (p_drdy3),
        .p_data  (p_data3),
        .p_last  (p_last3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors sample on the falling edge: a handshake seen here completes
    // on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            q4.delete();
            stall4 = 1'b0;
        end else begin
            if (stall4) begin
                check("stall4_data", p_data4, hd4);
                check("stall4_last", p_last4, hl4);
            end
            stall4 = p_srdy4 && !p_drdy4;
            hd4    = p_data4;
            hl4    = p_last4;
            if (c_srdy4 && c_drdy4) begin
                for (int k = 0; k <= int'(c_beats4); k++)
                    q4.push_back('{c_data4[k*8 +: 8], k == int'(c_beats4)});
                words4++;
            end
            if (p_srdy4 && p_drdy4) begin
                check("beat4_avail", q4.size() != 0, 1);
                if (q4.size() != 0) begin
                    beat_t e;
                    e = q4.pop_front();
                    check("beat4_data", p_data4, e.d);
                    check("beat4_last", p_last4, e.l);
                end
                if (p_last4) lasts4++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            q3.delete();
            stall3 = 1'b0;
        end else begin
            if (stall3) begin
                check("stall3_data", p_data3, hd3);
                check("stall3_last", p_last3, hl3);
            end
            stall3 = p_srdy3 && !p_drdy3;
            hd3    = p_data3;
            hl3    = p_last3;
            if (c_srdy3 && c_drdy3) begin
                int n;
                n = (c_beats3 > 2'd2) ? 2 : int'(c_beats3);
                for (int k = 0; k <= n; k++)
                    q3.push_back('{c_data3[k*8 +: 8], k == n});
                words3++;
            end
            if (p_srdy3 && p_drdy3) begin
                check("beat3_avail", q3.size() != 0, 1);
                if (q3.size() != 0) begin
                    beat_t e;
                    e = q3.pop_front();
                    check("beat3_data", p_data3, e.d);
                    check("beat3_last", p_last3, e.l);
                end
                if (p_last3) lasts3++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_w4, base_l4, base_w3, base_l3;

        reset    = 1'b1;
        c_srdy4  = 1'b0; c_data4 = '0; c_beats4 = '0; p_drdy4 = 1'b1;
        c_srdy3  = 1'b0; c_data3 = '0; c_beats3 = '0; p_drdy3 = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_c_drdy", c_drdy4, 1);
        check("rst_p_srdy", p_srdy4, 0);
        check("rst_p_last", p_last4, 0);
        check("rst_p_srdy3", p_srdy3, 0);

        // Single full word
        step();
        c_srdy4 = 1'b1; c_data4 = 32'h4433_2211; c_beats4 = 2'd3;
        step();
        c_srdy4 = 1'b0; c_data4 = 'x;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w1_c_drdy", c_drdy4, (i == 3));
            check("w1_p_last", p_last4, (i == 3));
            check("w1_p_srdy", p_srdy4, 1);
            step();
        end
        check("w1_empty", p_srdy4, 0);

        // Partial word
        c_srdy4 = 1'b1; c_data4 = 32'hDDCC_BBAA; c_beats4 = 2'd1;
        step();
        c_srdy4 = 1'b0; c_data4 = 'x;
        @(negedge clk);
        check("w2_b0", p_data4, 8'hAA);
        check("w2_l0", p_last4, 0);
        step();
        @(negedge clk);
        check("w2_b1", p_data4, 8'hBB);
        check("w2_l1", p_last4, 1);
        step();
        @(negedge clk);
        check("w2_empty", p_srdy4, 0);
        check("w2_c_drdy", c_drdy4, 1);

        // Back-to-back full words, no gap
        step();
        c_srdy4 = 1'b1; c_data4 = 32'h0403_0201; c_beats4 = 2'd3;
        step();
        c_data4 = 32'h0807_0605;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_p_srdy", p_srdy4, 1);
            check("b2b_p_data", p_data4, i + 1);
            if (i == 3) check("b2b_c_drdy", c_drdy4, 1);
            step();
            if (i == 3) begin
                c_srdy4 = 1'b0; c_data4 = 'x;
            end
        end
        check("b2b_empty", p_srdy4, 0);

        // Backpressure 1,0,0,...
        c_srdy4 = 1'b1; c_data4 = 32'h4433_2211; c_beats4 = 2'd3;
        step();
        c_srdy4 = 1'b0; c_data4 = 'x;
        for (int i = 0; i < 12; i++) begin
            p_drdy4 = (i % 3 == 0);
            step();
        end
        p_drdy4 = 1'b1;
        for (int i = 0; i < 20 && p_srdy4; i++) step();
        check("bp_drained", p_srdy4, 0);
        check("bp_queue", q4.size(), 0);

        // Asynchronous reset mid-word
        c_srdy4 = 1'b1; c_data4 = 32'hA4A3_A2A1; c_beats4 = 2'd3;
        step();
        c_srdy4 = 1'b0; c_data4 = 'x;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_p_srdy", p_srdy4, 0);
        check("arst_p_last", p_last4, 0);
        step(); step();
        reset = 1'b0;
        #1;
        check("arst_c_drdy", c_drdy4, 1);
        check("arst_idle", p_srdy4, 0);
        c_srdy4 = 1'b1; c_data4 = 32'h0000_00C1; c_beats4 = 2'd0;
        step();
        c_srdy4 = 1'b0; c_data4 = 'x;
        @(negedge clk);
        check("arst_b0", p_data4, 8'hC1);
        check("arst_l0", p_last4, 1);
        step();
        check("arst_done", p_srdy4, 0);

        // RATIO=3 with c_beats=3 clamps to three beats
        c_srdy3 = 1'b1; c_data3 = 24'h33_2211; c_beats3 = 2'd3;
        step();
        c_srdy3 = 1'b0; c_data3 = 'x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("clamp_p_last", p_last3, (i == 2));
            step();
        end
        check("clamp_empty", p_srdy3, 0);

        // Random stress on both instances
        base_w4 = words4; base_l4 = lasts4;
        base_w3 = words3; base_l3 = lasts3;
        for (int cyc = 0; cyc < 60000 && (words4 - base_w4) < 10000; cyc++) begin
            c_srdy4  = ($urandom_range(0, 7) != 0);
            c_data4  = c_srdy4 ? 32'($urandom) : 'x;
            c_beats4 = 2'($urandom_range(0, 3));
            p_drdy4  = ($urandom_range(0, 7) != 0);
            c_srdy3  = ($urandom_range(0, 7) != 0);
            c_data3  = c_srdy3 ? 24'($urandom) : 'x;
            c_beats3 = 2'($urandom_range(0, 3));
            p_drdy3  = ($urandom_range(0, 7) != 0);
            step();
        end
        check("rand_words", (words4 - base_w4) >= 10000, 1);
        c_srdy4 = 1'b0; c_data4 = 'x; p_drdy4 = 1'b1;
        c_srdy3 = 1'b0; c_data3 = 'x; p_drdy3 = 1'b1;
        for (int i = 0; i < 20 && (p_srdy4 || p_srdy3); i++) step();
        check("rand_q4_empty", q4.size(), 0);
        check("rand_q3_empty", q3.size(), 0);
        check("rand_last4", lasts4 - base_l4, words4 - base_w4);
        check("rand_last3", lasts3 - base_l3, words3 - base_w3);
        check("rand_idle4", p_srdy4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sd_dnsizer

`default_nettype wire

// File: doc/sd_dnsizer.md
Name: sd_dnsizer

Overview:
- Srdy/drdy width down-converter.
- Accepts one wide word of up to `ratio` narrow beats per handshake and emits the beats one per cycle on a narrow srdy/drdy interface, with a last-beat marker.
- Sits directly upstream of the narrow-path output closure stage; its p_* side drives that stage's internal consumer interface.
- All outputs except c_drdy come from flops (p_data through a beat-select mux). c_drdy is combinational from p_drdy.

Parameters:
- width, 8, narrow beat width in bits.
- ratio, 4, beats per wide word; legal range ≥2.
- cntw, clog2(ratio) (localparam), width of beat index and count fields.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- c_srdy  input  1  wide word valid.
- c_drdy  output  1  block can accept wide word this cycle.
- c_data  input  width*ratio  wide word; beat k = bits [k*width +: width].
- c_beats  input  cntw  number of valid beats minus 1 (0 = one beat).
- p_srdy  output  1  narrow beat valid.
- p_drdy  input  1  downstream accepts beat.
- p_data  output  width  current narrow beat.
- p_last  output  1  current beat is final beat of the word.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high, via the standard SDLIB clocking macro. Nonblocking assigns use the SDLIB delay macro.
- State: EMPTY, SEND.
  - Registers: w_data (width*ratio), w_last (cntw), idx (cntw).
  - p_srdy = (state==SEND), registered.
- Combinational terms:
  - drain_last = SEND & p_drdy & (idx==w_last).
  - c_drdy = EMPTY | drain_last.
  - load = c_srdy & c_drdy.
- Transitions:
  - EMPTY + load -> SEND: capture w_data=c_data, w_last=min(c_beats, ratio-1), idx=0.
  - SEND + p_drdy + idx!=w_last -> SEND, idx+1.
  - SEND + drain_last + load -> SEND: recapture word, idx=0. No bubble.
  - SEND + drain_last + !load -> EMPTY.
  - SEND + !p_drdy -> hold all state.
- Outputs:
  - p_data = w_data[idx*width +: width], beat 0 (LSBs) first.
  - p_last = (idx==w_last) & p_srdy.
- Stability: while p_srdy & !p_drdy, p_data/p_last must not change.
- Latency and throughput: word accepted in cycle N -> beat 0 presented in cycle N+1. Throughput is one beat per cycle. Sustained full words give one wide handshake every w_last+1 cycles with no idle cycles.
- Clamping: c_beats > ratio-1 (possible when ratio is not a power of 2) is clamped to ratio-1; no error flag.
- Reset:
  - state=EMPTY, p_srdy=0, idx=0, w_last=0.
  - w_data not reset.
  - c_drdy=1 immediately after reset deasserts.
  - Reset mid-word discards remaining beats; no partial beat is emitted afterwards.
- c_data/c_beats are ignored when load=0. X on c_data while c_srdy=0 must not propagate to state.

Decomposition:
- No package. The clocking/delay macros come from the shared SDLIB macro include; cntw is a local clog2 localparam.
- No sub-module; beat mux and FSM are flat in one module (~150 RTL lines).
- Full timing closure on p_* is achieved by instantiating the existing output closure stage downstream at integration level, not inside this block.

Test Plan:
- ratio=4, width=8, single word c_data=0x44332211, c_beats=3, p_drdy=1 -> p_data 11,22,33,44 on consecutive cycles; p_last only on 0x44; c_drdy low cycles 1-3, high with 0x44 drain.
- Partial word c_beats=1, c_data=0xDDCCBBAA -> beats AA,BB only; p_last on BB; return to EMPTY next cycle.
- Back-to-back full words 0x04030201, 0x08070605, c_srdy held high -> eight contiguous beats 01..08, no gap; second load in the same cycle as 0x04 drains.
- Backpressure: p_drdy toggled 1,0,0,1,... -> p_data/p_last stable during stalls; no beat dropped or duplicated; scoreboard matches.
- Reset asserted after beat 1 of 4 (asynchronous, mid-cycle) -> p_srdy=0 immediately; after release, c_drdy=1; next word's beat 0 is emitted with no leftover beats.
- Random stress: random c_srdy/p_drdy/c_beats (including c_beats=3 with ratio=3, clamped) over 10k words -> reference-model beat stream match; p_last count equals word count.
